// File: rtl/sc_datamem_io.sv
// Data RAM plus memory-mapped output/input channels for the single-cycle CPU.
// Optional input-change interrupt is built when IO_IRQ_EN is defined.
module sc_datamem_io #(
   parameter int IO_SEL_BIT = 7,
   parameter int NUM_OUT    = 4,
   parameter int NUM_IN     = 4,
   parameter int DATA_W     = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [31:0]             addr,
   input  logic [DATA_W-1:0]       datain,
   input  logic [3:0]              be,
   input  logic                    we,
   input  logic                    re,
   output logic [DATA_W-1:0]       dataout,
   output logic                    rvalid,
   output logic                    err,
   input  logic [NUM_IN*32-1:0]    in_ports,
   output logic [NUM_OUT*32-1:0]   out_ports,
   output logic                    irq
);

   localparam int DEPTH = 2 ** (IO_SEL_BIT - 2);

   logic [DATA_W-1:0] mem     [DEPTH];
   logic [DATA_W-1:0] out_reg [NUM_OUT];
   logic [DATA_W-1:0] sync1   [NUM_IN];
   logic [DATA_W-1:0] sync2   [NUM_IN];

   logic                    is_io;
   logic [4:0]              idx;
   logic [IO_SEL_BIT-3:0]   ram_idx;
   logic [DATA_W-1:0]       lane_m;
   logic [DATA_W-1:0]       io_rdata;
   logic                    rd_mapped;
   logic                    wr_mapped;
   logic [NUM_OUT-1:0]      out_sel;
   logic                    mask_sel;
   logic                    pend_sel;
   logic                    unused_ok;

`ifdef IO_IRQ_EN
   logic [DATA_W-1:0] prev [NUM_IN];
   logic [NUM_IN-1:0] mask;
   logic [NUM_IN-1:0] pend;
   logic [NUM_IN-1:0] pend_set;
   logic [NUM_IN-1:0] pend_clr;
   logic              irq_q;
`endif

   assign is_io     = addr[IO_SEL_BIT];
   assign idx       = addr[6:2];
   assign ram_idx   = addr[IO_SEL_BIT-1:2];
   assign lane_m    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign unused_ok = &{1'b0, addr[31:IO_SEL_BIT+1], addr[1:0]};

   always_comb begin
      io_rdata  = '0;
      rd_mapped = 1'b0;
      wr_mapped = 1'b0;
      out_sel   = '0;
      mask_sel  = 1'b0;
      pend_sel  = 1'b0;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
         if (idx == 5'(k)) begin
            io_rdata   = out_reg[k];
            rd_mapped  = 1'b1;
            wr_mapped  = 1'b1;
            out_sel[k] = 1'b1;
         end
      end
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (idx == 5'(16 + k)) begin
            io_rdata  = sync2[k];
            rd_mapped = 1'b1;
         end
      end
`ifdef IO_IRQ_EN
      if (idx == 5'd30) begin
         io_rdata  = DATA_W'(mask);
         rd_mapped = 1'b1;
         wr_mapped = 1'b1;
         mask_sel  = 1'b1;
      end
      if (idx == 5'd31) begin
         io_rdata  = DATA_W'(pend);
         rd_mapped = 1'b1;
         wr_mapped = 1'b1;
         pend_sel  = 1'b1;
      end
`endif
   end

   always_comb begin
      out_ports = '0;
      for (int unsigned k = 0; k < NUM_OUT; k++)
         out_ports[32*k +: 32] = out_reg[k];
   end

   // RAM is never reset; the reset guard only keeps reset-with-we from writing.
   always_ff @(posedge clock) begin
      if (!reset && we && !is_io)
         mem[ram_idx] <= (mem[ram_idx] & ~lane_m) | (datain & lane_m);
   end

   // Non-blocking reads of mem/out_reg give read-first on a same-cycle we&re.
   always_ff @(posedge clock) begin
      if (reset) begin
         dataout <= '0;
         rvalid  <= 1'b0;
         err     <= 1'b0;
         for (int unsigned k = 0; k < NUM_OUT; k++)
            out_reg[k] <= '0;
      end else begin
         rvalid <= re;
         err    <= is_io && ((re && !rd_mapped) || (we && !wr_mapped));
         if (re)
            dataout <= is_io ? io_rdata : mem[ram_idx];
         if (we && is_io) begin
            for (int unsigned k = 0; k < NUM_OUT; k++)
               if (out_sel[k])
                  out_reg[k] <= (out_reg[k] & ~lane_m) | (datain & lane_m);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned k = 0; k < NUM_IN; k++) begin
            sync1[k] <= '0;
            sync2[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NUM_IN; k++) begin
            sync1[k] <= in_ports[32*k +: 32];
            sync2[k] <= sync1[k];
         end
      end
   end

`ifdef IO_IRQ_EN
   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      for (int unsigned k = 0; k < NUM_IN; k++)
         pend_set[k] = (sync2[k] != prev[k]);
      if (we && is_io && pend_sel)
         pend_clr = datain[NUM_IN-1:0] & lane_m[NUM_IN-1:0];
   end

   // Set is applied after clear so a simultaneous change keeps the bit pending.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned k = 0; k < NUM_IN; k++)
            prev[k] <= '0;
         mask  <= '0;
         pend  <= '0;
         irq_q <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NUM_IN; k++)
            prev[k] <= sync2[k];
         if (we && is_io && mask_sel)
            mask <= (mask & ~lane_m[NUM_IN-1:0]) | (datain[NUM_IN-1:0] & lane_m[NUM_IN-1:0]);
         pend  <= (pend & ~pend_clr) | pend_set;
         irq_q <= |(pend & mask);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_sc_datamem_io.sv
// Directed self-checking bench for sc_datamem_io (default parameters).
// IRQ steps are compiled only when IO_IRQ_EN is defined.
module tb_sc_datamem_io;

   logic          clock;
   logic          reset;
   logic [31:0]   addr;
   logic [31:0]   datain;
   logic [3:0]    be;
   logic          we;
   logic          re;
   logic [31:0]   dataout;
   logic          rvalid;
   logic          err;
   logic [127:0]  in_ports;
   logic [127:0]  out_ports;
   logic          irq;

   int n_checks = 0;
   int n_errors = 0;

   sc_datamem_io #(
      .IO_SEL_BIT (7),
      .NUM_OUT    (4),
      .NUM_IN     (4),
      .DATA_W     (32)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .addr      (addr),
      .datain    (datain),
      .be        (be),
      .we        (we),
      .re        (re),
      .dataout   (dataout),
      .rvalid    (rvalid),
      .err       (err),
      .in_ports  (in_ports),
      .out_ports (out_ports),
      .irq       (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
      we     = w;
      re     = r;
      addr   = a;
      datain = d;
      be     = b;
   endtask

   task automatic idle();
      bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_ports = '0;
      in_ports[127:96] = 32'hCAFE0003;
      idle();
      tick();
      tick();
      chk("reset_dataout", dataout, 0);
      chk("reset_rvalid", rvalid, 0);
      chk("reset_err", err, 0);
      chk("reset_out_ports", out_ports, 0);
      chk("reset_irq", irq, 0);

      // reset held together with we/re
      bus(1'b1, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF);
      tick();
      chk("rst_wins_rvalid", rvalid, 0);
      chk("rst_wins_err", err, 0);
      chk("rst_wins_out", out_ports, 0);
      reset = 1'b0;
      idle();
      tick();

      // RAM byte-lane write
      bus(1'b1, 1'b0, 32'h0C, 32'h11223344, 4'hF);
      tick();
      chk("ram_wr_err", err, 0);
      chk("ram_wr_rvalid", rvalid, 0);
      bus(1'b1, 1'b0, 32'h0C, 32'hAABBCCDD, 4'b0100);
      tick();
      bus(1'b0, 1'b1, 32'h0C, 32'h0, 4'h0);
      tick();
      chk("ram_lane_data", dataout, 32'h11BB3344);
      chk("ram_lane_rvalid", rvalid, 1);
      chk("ram_lane_err", err, 0);
      idle();
      tick();
      chk("rvalid_pulse", rvalid, 0);
      chk("dataout_hold", dataout, 32'h11BB3344);

      // read-first on same-cycle we&re
      bus(1'b1, 1'b0, 32'h10, 32'h5, 4'hF);
      tick();
      bus(1'b1, 1'b1, 32'h10, 32'h9, 4'hF);
      tick();
      chk("read_first_old", dataout, 32'h5);
      chk("read_first_rvalid", rvalid, 1);
      bus(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
      tick();
      chk("read_after_new", dataout, 32'h9);

      // be=0 write is a no-op and not an error
      bus(1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 4'h0);
      tick();
      chk("be0_err", err, 0);
      bus(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
      tick();
      chk("be0_unchanged", dataout, 32'h9);

      // top RAM word
      bus(1'b1, 1'b0, 32'h7C, 32'h0BADF00D, 4'hF);
      tick();
      chk("ram_top_err", err, 0);
      bus(1'b0, 1'b1, 32'h7C, 32'h0, 4'h0);
      tick();
      chk("ram_top_data", dataout, 32'h0BADF00D);

      // output channels
      bus(1'b1, 1'b0, 32'h84, 32'hDEADBEEF, 4'hF);
      tick();
      chk("out1_port", out_ports[63:32], 32'hDEADBEEF);
      chk("out_others", {out_ports[127:64], out_ports[31:0]}, 0);
      chk("out1_err", err, 0);
      bus(1'b1, 1'b0, 32'h8C, 32'h123456A5, 4'b0001);
      tick();
      chk("out3_lane", out_ports[127:96], 32'h000000A5);
      bus(1'b0, 1'b1, 32'h84, 32'h0, 4'h0);
      tick();
      chk("out1_readback", dataout, 32'hDEADBEEF);

      // input synchroniser latency
      in_ports[31:0] = 32'h1234;
      idle();
      tick();
      bus(1'b0, 1'b1, 32'hC0, 32'h0, 4'h0);
      tick();
      chk("in_sync_early", dataout, 32'h0);
      tick();
      chk("in_sync_late", dataout, 32'h1234);
      chk("in_read_err", err, 0);
      bus(1'b0, 1'b1, 32'hCC, 32'h0, 4'h0);
      tick();
      chk("in3_read", dataout, 32'hCAFE0003);

      // access errors
      bus(1'b0, 1'b1, 32'hB0, 32'h0, 4'h0);
      tick();
      chk("unmap_rd_data", dataout, 0);
      chk("unmap_rd_rvalid", rvalid, 1);
      chk("unmap_rd_err", err, 1);
      idle();
      tick();
      chk("err_pulse", err, 0);
      bus(1'b1, 1'b0, 32'hC0, 32'hFFFFFFFF, 4'hF);
      tick();
      chk("in_wr_err", err, 1);
      bus(1'b0, 1'b1, 32'hC0, 32'h0, 4'h0);
      tick();
      chk("in_wr_unchanged", dataout, 32'h1234);
      chk("in_rd_noerr", err, 0);
      bus(1'b1, 1'b0, 32'hA0, 32'hFFFFFFFF, 4'hF);
      tick();
      chk("unmap_wr_err", err, 1);
      chk("unmap_wr_out", out_ports[31:0], 0);
      bus(1'b0, 1'b1, 32'hD0, 32'h0, 4'h0);
      tick();
      chk("in_past_end_err", err, 1);

`ifdef IO_IRQ_EN
      bus(1'b1, 1'b0, 32'hFC, 32'hF, 4'hF);
      tick();
      chk("pend_clr_err", err, 0);
      bus(1'b1, 1'b0, 32'hF8, 32'h1, 4'hF);
      tick();
      bus(1'b0, 1'b1, 32'hF8, 32'h0, 4'h0);
      tick();
      chk("mask_read", dataout, 32'h1);
      bus(1'b0, 1'b1, 32'hFC, 32'h0, 4'h0);
      tick();
      chk("pend_clear", dataout, 32'h0);
      chk("irq_idle", irq, 0);
      in_ports[31:0] = 32'h1235;
      idle();
      tick();
      tick();
      tick();
      chk("irq_edge3", irq, 0);
      tick();
      chk("irq_edge4", irq, 1);
      in_ports[31:0] = 32'h1234;
      tick();
      tick();
      bus(1'b1, 1'b0, 32'hFC, 32'h1, 4'hF);
      tick();
      bus(1'b0, 1'b1, 32'hFC, 32'h0, 4'h0);
      tick();
      chk("pend_set_wins", dataout, 32'h1);
      chk("irq_held", irq, 1);
      bus(1'b1, 1'b0, 32'hFC, 32'h1, 4'hF);
      tick();
      bus(1'b0, 1'b1, 32'hFC, 32'h0, 4'h0);
      tick();
      chk("pend_w1c", dataout, 32'h0);
      chk("irq_cleared", irq, 0);
`else
      bus(1'b0, 1'b1, 32'hF8, 32'h0, 4'h0);
      tick();
      chk("idx30_rd_err", err, 1);
      chk("idx30_rd_data", dataout, 0);
      bus(1'b1, 1'b0, 32'hFC, 32'h1, 4'hF);
      tick();
      chk("idx31_wr_err", err, 1);
      chk("irq_tied", irq, 0);
`endif

      // final reset clears outputs
      idle();
      reset = 1'b1;
      tick();
      chk("reset2_out", out_ports, 0);
      chk("reset2_dataout", dataout, 0);
      reset = 1'b0;
      bus(1'b0, 1'b1, 32'h0C, 32'h0, 4'h0);
      tick();
      chk("ram_survives_reset", dataout, 32'h11BB3344);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
